// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and a 1-entry hold buffer
// that parks a fetch completing under stall so it is neither lost nor refetched.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        dbg_held
);

  // Handshake: a fetch completes on an edge where imem_req=1 and imem_ready=1;
  // imem_req is deasserted while the hold buffer is occupied.
  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc_plus4;
  logic        hit;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = {pc[31:2], 2'b00};
  assign imem_req  = rst_n & (state == EMPTY);
  assign hit       = imem_req & imem_ready;
  assign dbg_held  = (state == HELD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= EMPTY;
      pc             <= RESET_PC;
      buf_instr      <= NOP_INSTR;
      buf_pc_plus4   <= 32'd0;
      id_instruction <= NOP_INSTR;
      id_pc_plus4    <= 32'd0;
      id_valid       <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over stall and drops any same-cycle fetch data.
      state          <= EMPTY;
      pc             <= redirect_target & 32'hFFFF_FFFC;
      id_instruction <= NOP_INSTR;
      id_pc_plus4    <= 32'd0;
      id_valid       <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (hit) pc <= pc_plus4;
          if (stall && hit) begin
            state        <= HELD;
            buf_instr    <= imem_rdata;
            buf_pc_plus4 <= pc_plus4;
          end
          if (flush || (!stall && !hit)) begin
            id_instruction <= NOP_INSTR;
            id_pc_plus4    <= 32'd0;
            id_valid       <= 1'b0;
          end else if (!stall) begin
            id_instruction <= imem_rdata;
            id_pc_plus4    <= pc_plus4;
            id_valid       <= 1'b1;
          end
        end
        HELD: begin
          if (!stall) state <= EMPTY;
          if (flush) begin
            id_instruction <= NOP_INSTR;
            id_pc_plus4    <= 32'd0;
            id_valid       <= 1'b0;
          end else if (!stall) begin
            id_instruction <= buf_instr;
            id_pc_plus4    <= buf_pc_plus4;
            id_valid       <= 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_ready = 1'b0;
  logic [31:0] id_instruction;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        dbg_held;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  // Behavioural model: PC, at most one parked fetch, and the IF/ID contents.
  logic [31:0] m_pc;
  logic [31:0] m_id_i, m_id_p4;
  logic        m_id_v;
  logic [63:0] m_park[$];

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .id_instruction(id_instruction),
    .id_pc_plus4(id_pc_plus4), .id_valid(id_valid), .dbg_held(dbg_held)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0001;
    if (a == 32'h4) return 32'h2009_0002;
    return {8'h3C, a[23:0]} ^ {a[7:0], 24'h5A5A5A};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Apply one cycle of inputs; the model advances to the post-edge state.
  task automatic step(input logic r, input logic s, input logic f, input logic rv,
                      input logic [31:0] tgt, input logic rdy);
    logic        fetched;
    logic        deliver;
    logic [63:0] got;
    rst_n = r; stall = s; flush = f; redirect_valid = rv;
    redirect_target = tgt; imem_ready = rdy;
    imem_rdata = rdy ? mem_word(imem_addr) : $urandom;
    deliver = 1'b0;
    got = 64'd0;
    if (!r) begin
      m_pc = 32'h0; m_park.delete();
      m_id_i = 32'h0; m_id_p4 = 32'h0; m_id_v = 1'b0;
    end else if (rv) begin
      m_pc = {tgt[31:2], 2'b00}; m_park.delete();
      m_id_i = 32'h0; m_id_p4 = 32'h0; m_id_v = 1'b0;
    end else begin
      fetched = (m_park.size() == 0) && rdy;
      if (fetched) begin
        got = {mem_word(m_pc), m_pc + 32'd4};
        m_pc = m_pc + 32'd4;
        if (s) m_park.push_back(got);
        else deliver = 1'b1;
      end else if (m_park.size() != 0 && !s) begin
        got = m_park.pop_front();
        deliver = 1'b1;
      end
      if (f || (!deliver && !s)) begin
        m_id_i = 32'h0; m_id_p4 = 32'h0; m_id_v = 1'b0;
      end else if (deliver) begin
        m_id_i = got[63:32]; m_id_p4 = got[31:0]; m_id_v = 1'b1;
      end
    end
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", {31'd0, imem_req}, {31'd0, rst_n && (m_park.size() == 0)});
      chk("imem_addr", imem_addr, m_pc);
      chk("id_instruction", id_instruction, m_id_i);
      chk("id_pc_plus4", id_pc_plus4, m_id_p4);
      chk("id_valid", {31'd0, id_valid}, {31'd0, m_id_v});
      chk("held", {31'd0, dbg_held}, {31'd0, m_park.size() == 1});
    end
  end

  initial begin
    // Reset then first fetches
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("lit_reset_req", {31'd0, imem_req}, 32'd0);
    chk("lit_reset_valid", {31'd0, id_valid}, 32'd0);
    chk("lit_reset_addr", imem_addr, 32'h0);
    step(1, 0, 0, 0, 0, 1);
    chk("lit_first_instr", id_instruction, 32'h2008_0001);
    chk("lit_first_pc4", id_pc_plus4, 32'h4);
    chk("lit_first_valid", {31'd0, id_valid}, 32'd1);
    step(1, 0, 0, 0, 0, 1);
    chk("lit_second_instr", id_instruction, 32'h2009_0002);
    chk("lit_addr_8", imem_addr, 32'h8);
    // Wait states at PC=8
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0);
      chk("lit_wait_valid", {31'd0, id_valid}, 32'd0);
      chk("lit_wait_addr", imem_addr, 32'h8);
    end
    step(1, 0, 0, 0, 0, 1);
    chk("lit_wait_done_pc4", id_pc_plus4, 32'hC);
    step(1, 0, 0, 0, 0, 1);
    // Stall capture at PC=0x10
    step(1, 1, 0, 0, 0, 1);
    chk("lit_stall_held", {31'd0, dbg_held}, 32'd1);
    chk("lit_stall_addr", imem_addr, 32'h14);
    chk("lit_stall_req", {31'd0, imem_req}, 32'd0);
    chk("lit_stall_id_pc4", id_pc_plus4, 32'h10);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("lit_release_pc4", id_pc_plus4, 32'h14);
    chk("lit_release_instr", id_instruction, mem_word(32'h10));
    chk("lit_release_addr", imem_addr, 32'h14);
    // Redirect over stall while HELD
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 1, 32'h0000_0403, 1);
    chk("lit_redir_addr", imem_addr, 32'h400);
    chk("lit_redir_held", {31'd0, dbg_held}, 32'd0);
    chk("lit_redir_valid", {31'd0, id_valid}, 32'd0);
    step(1, 0, 0, 0, 0, 1);
    chk("lit_redir_pc4", id_pc_plus4, 32'h404);
    // Flush with a hit at 0x20
    step(1, 0, 0, 1, 32'h20, 1);
    step(1, 0, 1, 0, 0, 1);
    chk("lit_flush_valid", {31'd0, id_valid}, 32'd0);
    chk("lit_flush_addr", imem_addr, 32'h24);
    step(1, 0, 0, 0, 0, 1);
    chk("lit_after_flush_pc4", id_pc_plus4, 32'h28);
    // PC wrap
    step(1, 0, 0, 1, 32'hFFFF_FFFC, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("lit_wrap_pc4", id_pc_plus4, 32'h0);
    chk("lit_wrap_addr", imem_addr, 32'h0);
    // Reset while HELD
    step(1, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    chk("lit_midrst_addr", imem_addr, 32'h0);
    chk("lit_midrst_held", {31'd0, dbg_held}, 32'd0);
    chk("lit_midrst_valid", {31'd0, id_valid}, 32'd0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
           $urandom, ($urandom_range(0, 9) < 7));
    end
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
